// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Load/store unit front end. It accepts one request at a time, decodes it
// into an internal byte-laned RAM or an external IO window, and returns a
// single-cycle response pulse. Illegal accesses (unmapped, bad size,
// misaligned) are answered with rsp_err and have no side effects.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : request channel (valid/ready, we, addr, wdata,
//                       size 0=byte 1=half 2=word, unsigned-load flag)
//   rsp_*             : one-cycle response (valid, rdata, err)
//   io_*              : external IO handshake (valid/ready, we, addr,
//                       lane-replicated wdata, byte strobes, rdata)
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned IO_BASE    = 32'h0000_F000,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              io_valid,
  input  logic              io_ready,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [31:0]       io_wdata,
  output logic [3:0]        io_wstrb,
  input  logic [31:0]       io_rdata
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  localparam logic [32:0] IO_FIRST  = 33'(IO_BASE);
  localparam logic [7:0]  TMO_LAST  = 8'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM     = 2'd1,
    IO_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered outputs
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;
  logic              r_io_valid;
  logic              r_io_we;
  logic [ADDR_W-1:0] r_io_addr;
  logic [31:0]       r_io_wdata;
  logic [3:0]        r_io_wstrb;

  // Attributes of the request in flight
  logic              r_we;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [7:0]        r_cnt;
  logic [31:0]       r_word;

  logic [31:0]       r_mem [RAM_WORDS];

  // Request decode
  logic              w_accept;
  logic              w_is_ram;
  logic              w_is_io;
  logic              w_misalign;
  logic              w_req_err;
  logic [1:0]        w_off;
  logic [3:0]        w_strb;
  logic [31:0]       w_wdata_rep;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_ram_we;
  logic              w_ram_re;

  // Shift the addressed lane down, truncate to size, then sign/zero extend
  function automatic logic [31:0] load_ext(input logic [31:0] i_word,
                                           input logic [1:0]  i_off,
                                           input logic [1:0]  i_size,
                                           input logic        i_uns);
    logic [31:0] v_sh;
    logic [31:0] v_res;
    v_sh = i_word >> {i_off, 3'b000};
    case (i_size)
      2'd0:    v_res = i_uns ? {24'h0, v_sh[7:0]}  : {{24{v_sh[7]}},  v_sh[7:0]};
      2'd1:    v_res = i_uns ? {16'h0, v_sh[15:0]} : {{16{v_sh[15]}}, v_sh[15:0]};
      default: v_res = i_word;
    endcase
    return v_res;
  endfunction

  // Address/size decode, lane strobes and write-data replication
  always_comb begin
    w_off       = req_addr[1:0];
    w_accept    = req_valid && r_req_ready && !rst;
    w_is_ram    = 33'(req_addr) < RAM_BYTES;
    w_is_io     = !w_is_ram && (33'(req_addr) >= IO_FIRST);
    w_ram_idx   = req_addr[RAM_AW+1:2];
    w_misalign  = 1'b0;
    w_strb      = 4'hF;
    w_wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin
        w_strb      = 4'b0001 << w_off;
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_misalign  = w_off[0];
        w_strb      = 4'b0011 << w_off;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      2'd2:    w_misalign = (w_off != 2'd0);
      default: w_misalign = 1'b1;
    endcase
    w_req_err = w_misalign || !(w_is_ram || w_is_io);
    w_ram_we  = w_accept && !w_req_err && w_is_ram && req_we;
    w_ram_re  = w_accept && !w_req_err && w_is_ram && !req_we;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)     w_state_nxt = RESP;
          else if (w_is_ram) w_state_nxt = RAM;
          else               w_state_nxt = IO_WAIT;
        end
      end
      RAM:     w_state_nxt = RESP;
      IO_WAIT: if (io_ready || (r_cnt == TMO_LAST)) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response, IO channel and in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_io_valid  <= 1'b0;
      r_io_we     <= 1'b0;
      r_io_addr   <= '0;
      r_io_wdata  <= '0;
      r_io_wstrb  <= '0;
      r_we        <= 1'b0;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      // Response data/err only live for the single RESP cycle
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we   <= req_we;
            r_off  <= w_off;
            r_size <= req_size;
            r_uns  <= req_unsigned;
            r_cnt  <= '0;
            if (w_req_err) begin
              r_rsp_err <= 1'b1;
            end else if (w_is_io) begin
              r_io_valid <= 1'b1;
              r_io_we    <= req_we;
              r_io_addr  <= req_addr;
              r_io_wdata <= w_wdata_rep;
              r_io_wstrb <= req_we ? w_strb : 4'h0;
            end
          end
        end
        RAM: begin
          r_rsp_rdata <= r_we ? 32'h0 : load_ext(r_word, r_off, r_size, r_uns);
        end
        IO_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (io_ready) begin
            r_io_valid  <= 1'b0;
            r_io_wstrb  <= 4'h0;
            r_rsp_rdata <= r_we ? 32'h0 : load_ext(io_rdata, r_off, r_size, r_uns);
          end else if (r_cnt == TMO_LAST) begin
            r_io_valid <= 1'b0;
            r_io_wstrb <= 4'h0;
            r_rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-laned RAM; contents survive reset, only one access per request
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) r_mem[w_ram_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
    if (w_ram_re) r_word <= r_mem[w_ram_idx];
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign io_valid  = r_io_valid;
  assign io_we     = r_io_we;
  assign io_addr   = r_io_addr;
  assign io_wdata  = r_io_wdata;
  assign io_wstrb  = r_io_wstrb;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter RAM_WORDS, default 4096, RAM depth in 32-bit words (power of 2).
REQ-003 SHALL have parameter IO_BASE, default 16'hF000, first byte address of the IO window (window runs to the top of the address space).
REQ-004 SHALL have parameter IO_TIMEOUT, default 15, max IO wait cycles (1..255).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports req_valid in 1 and req_ready out 1, request handshake.
REQ-008 SHALL have ports req_we in 1, req_addr in ADDR_W, req_wdata in 32, request fields.
REQ-009 SHALL have ports req_size in 2 (0=byte, 1=half, 2=word, 3=illegal) and req_unsigned in 1 (zero-extend loads).
REQ-010 SHALL have ports rsp_valid out 1, rsp_rdata out 32, rsp_err out 1, one-cycle response pulse.
REQ-011 SHALL have ports io_valid out 1, io_ready in 1, io_we out 1, io_addr out ADDR_W, io_wdata out 32, io_wstrb out 4, io_rdata in 32, external IO handshake.

Function
REQ-012 SHALL accept a request when req_valid && req_ready; req_ready is high only in state IDLE.
REQ-013 SHALL implement FSM states IDLE, RAM, IO_WAIT, RESP.
REQ-014 SHALL decode: addr < RAM_WORDS*4 -> RAM; addr >= IO_BASE -> IO; else unmapped.
REQ-015 SHALL flag error on accept for: unmapped address, req_size==3, half with addr[0]=1, word with addr[1:0]!=0; then go to RESP with no RAM write and no IO cycle.
REQ-016 SHALL compute lane strobes: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
REQ-017 SHALL replicate write data onto lanes (byte data on all four lanes, half data on both halves).
REQ-018 SHALL, on a legal RAM write, update only strobed bytes of word addr[ADDR_W-1:2] at the accept edge, go to RAM, and pulse rsp_valid with rsp_err=0, rsp_rdata=0 in the next cycle.
REQ-019 SHALL, on a legal RAM read, register the word at the accept edge and present rsp_valid exactly 1 cycle after accept.
REQ-020 SHALL form load data as word >> (addr[1:0]*8), truncated to size, then sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1); word loads unmodified.
REQ-021 SHALL, on a legal IO access, enter IO_WAIT and drive io_valid=1 with io_we, io_addr, aligned io_wdata, io_wstrb (0 on reads) held stable until io_ready.
REQ-022 SHALL complete IO on the cycle io_valid && io_ready: capture io_rdata (read extraction per REQ-020), deassert io_valid next cycle, go to RESP.
REQ-023 SHALL count IO_WAIT cycles from 0; if io_ready is not seen by count IO_TIMEOUT, drop io_valid and go to RESP with rsp_err=1.
REQ-024 SHALL hold RESP for exactly one cycle (rsp_valid=1), then return to IDLE; back-to-back accept is possible on the following cycle.
REQ-025 SHALL drive rsp_rdata=0 whenever rsp_err=1 or rsp_valid=0.
REQ-026 SHALL make RAM read-during-write to the same word impossible (one outstanding request).

Reset
REQ-027 SHALL, while rst=1, force state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, io_valid=0, io_wstrb=0, and clear the timeout counter; req_ready=1 on the first cycle after reset.
REQ-028 SHALL abandon any in-flight RAM/IO transaction on reset with no response; RAM contents are not reset.

Verification
REQ-029 SHALL cover: word write 0xDEADBEEF @0x0010, then byte read @0x0013 signed -> rsp_rdata 0xFFFFFFDE, 1-cycle latency; unsigned -> 0x000000DE.
REQ-030 SHALL cover: half write 0x1234 @0x0022 onto word 0 -> word read @0x0020 returns 0x12340000; lanes 0-1 unchanged.
REQ-031 SHALL cover: word read @0x0002 and req_size=3 -> rsp_err=1, rsp_rdata=0, RAM unchanged, io_valid never asserted.
REQ-032 SHALL cover: IO write @0xF004 with io_ready delayed 3 cycles -> io_valid held 4 cycles, io_wstrb=4'hF, rsp_valid 1 cycle after handshake, rsp_err=0.
REQ-033 SHALL cover: IO read with io_ready tied 0 -> io_valid drops after IO_TIMEOUT cycles, rsp_err=1.
REQ-034 SHALL cover: rst asserted during IO_WAIT -> io_valid=0 next cycle, no rsp_valid, req_ready=1 after reset release.
